// File: rtl/rgb2hsv_seq.sv
// rtl/rgb2hsv_seq.sv - RGB to hue/sat/value converter built around one shared iterative restoring divider.
// Optional saturation stage: define RGB2HSV_SAT_EN; without it sat is tied to 0 and latency is DIV_W.
module rgb2hsv_seq #(
  parameter int PIXEL_W = 8,
  parameter int FRAC    = 4,
  parameter int HUE_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] r,
  input  logic [PIXEL_W-1:0] g,
  input  logic [PIXEL_W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [HUE_W-1:0]   hue,
  output logic [PIXEL_W-1:0] sat,
  output logic [PIXEL_W-1:0] val
);

  localparam int DIV_W = (PIXEL_W + FRAC + 6 > 2 * PIXEL_W) ? PIXEL_W + FRAC + 6 : 2 * PIXEL_W;
  localparam int CNT_W = $clog2(DIV_W);
  localparam int MAXV  = (1 << PIXEL_W) - 1;

  typedef logic [DIV_W:0] hacc_t;
  typedef enum logic [1:0] {SEL_R, SEL_G, SEL_B} sel_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_HUE,
`ifdef RGB2HSV_SAT_EN
    S_SAT,
`endif
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PIXEL_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0]   dvd_q, dvd_d;
  logic [PIXEL_W-1:0] dvs_q, dvs_d;
  sel_e               sel_q, sel_d;
  logic               ge_q, ge_d;
  logic [PIXEL_W-1:0] cmax_q, cmax_d;
  logic [PIXEL_W-1:0] diff_q, diff_d;
  logic [HUE_W-1:0]   hue_q, hue_d;
  logic [PIXEL_W-1:0] sat_q, sat_d;
  logic [PIXEL_W-1:0] val_q, val_d;
`ifdef RGB2HSV_SAT_EN
  logic [HUE_W-1:0]   hue_tmp_q, hue_tmp_d;
  logic [DIV_W-1:0]   dvd_sat;
`endif

  sel_e               in_sel;
  logic               in_ge;
  logic [PIXEL_W-1:0] in_max, in_min, in_n, in_diff;
  logic [DIV_W-1:0]   dvd_hue;

  logic [PIXEL_W:0]   trial, sub;
  logic               bit_ok;
  logic [PIXEL_W-1:0] rem_step;
  logic [DIV_W-1:0]   quo_step;
  hacc_t              hue_base, hue_fix;
  logic [HUE_W-1:0]   hue_new;
  logic               last_iter;

  // Channel ranking at accept; in_ge selects the +q / -q branch of the sector formula.
  always_comb begin
    in_sel = SEL_B;
    in_ge  = 1'b0;
    in_max = b;
    in_min = b;
    in_n   = '0;
    if (r >= g && r >= b) begin
      in_sel = SEL_R;
      in_max = r;
      in_ge  = (g >= b);
      in_min = in_ge ? b : g;
      in_n   = in_ge ? g - b : b - g;
    end else if (g >= b) begin
      in_sel = SEL_G;
      in_max = g;
      in_ge  = (b >= r);
      in_min = in_ge ? r : b;
      in_n   = in_ge ? b - r : r - b;
    end else begin
      in_sel = SEL_B;
      in_max = b;
      in_ge  = (r >= g);
      in_min = in_ge ? g : r;
      in_n   = in_ge ? r - g : g - r;
    end
    in_diff = in_max - in_min;
    dvd_hue = (DIV_W'(in_n) * DIV_W'(60)) << FRAC;
  end

  // One restoring step: dvd_q shifts left and collects quotient bits in its LSBs.
  always_comb begin
    trial     = {rem_q, dvd_q[DIV_W-1]};
    sub       = trial - {1'b0, dvs_q};
    bit_ok    = (trial >= {1'b0, dvs_q});
    rem_step  = bit_ok ? PIXEL_W'(sub) : PIXEL_W'(trial);
    quo_step  = {dvd_q[DIV_W-2:0], bit_ok};
    last_iter = (cnt_q == CNT_W'(DIV_W - 1));
  end

  always_comb begin
    hue_base = '0;
    unique case (sel_q)
      SEL_R:   hue_base = ge_q ? hacc_t'(0) : hacc_t'(360 << FRAC);
      SEL_G:   hue_base = hacc_t'(120 << FRAC);
      default: hue_base = hacc_t'(240 << FRAC);
    endcase
    hue_fix = ge_q ? hue_base + {1'b0, quo_step} : hue_base - {1'b0, quo_step};
    hue_new = (diff_q == '0) ? '0 : HUE_W'(hue_fix >> FRAC);
  end

`ifdef RGB2HSV_SAT_EN
  assign dvd_sat = DIV_W'(diff_q) * DIV_W'(MAXV);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sel_d   = sel_q;
    ge_d    = ge_q;
    cmax_d  = cmax_q;
    diff_d  = diff_q;
    hue_d   = hue_q;
    sat_d   = sat_q;
    val_d   = val_q;
`ifdef RGB2HSV_SAT_EN
    hue_tmp_d = hue_tmp_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sel_d   = in_sel;
          ge_d    = in_ge;
          cmax_d  = in_max;
          diff_d  = in_diff;
          dvd_d   = dvd_hue;
          dvs_d   = in_diff;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_HUE;
        end
      end
      S_HUE: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          cnt_d = '0;
`ifdef RGB2HSV_SAT_EN
          hue_tmp_d = hue_new;
          dvd_d     = dvd_sat;
          dvs_d     = cmax_q;
          rem_d     = '0;
          state_d   = S_SAT;
`else
          hue_d   = hue_new;
          sat_d   = '0;
          val_d   = cmax_q;
          state_d = S_DONE;
`endif
        end
      end
`ifdef RGB2HSV_SAT_EN
      S_SAT: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          cnt_d   = '0;
          hue_d   = hue_tmp_q;
          sat_d   = (diff_q == '0) ? '0 : PIXEL_W'(quo_step);
          val_d   = cmax_q;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sel_q   <= SEL_R;
      ge_q    <= 1'b0;
      cmax_q  <= '0;
      diff_q  <= '0;
      hue_q   <= '0;
      sat_q   <= '0;
      val_q   <= '0;
`ifdef RGB2HSV_SAT_EN
      hue_tmp_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sel_q   <= sel_d;
      ge_q    <= ge_d;
      cmax_q  <= cmax_d;
      diff_q  <= diff_d;
      hue_q   <= hue_d;
      sat_q   <= sat_d;
      val_q   <= val_d;
`ifdef RGB2HSV_SAT_EN
      hue_tmp_q <= hue_tmp_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign hue       = hue_q;
  assign sat       = sat_q;
  assign val       = val_q;

endmodule

// File: tb/tb_rgb2hsv_seq.sv
// tb/tb_rgb2hsv_seq.sv - directed self-checking bench for rgb2hsv_seq (honours RGB2HSV_SAT_EN).
module tb_rgb2hsv_seq;

  localparam int DIV_W = 18;
`ifdef RGB2HSV_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif
  localparam int LAT = SAT_ON ? 2 * DIV_W : DIV_W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       in_ready, out_valid;
  logic [8:0] hue;
  logic [7:0] sat, val;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rgb2hsv_seq #(.PIXEL_W(8), .FRAC(4), .HUE_W(9)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .r(r), .g(g), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .hue(hue), .sat(sat), .val(val)
  );

  function automatic int exp_sat(input int s);
    return SAT_ON ? s : 0;
  endfunction

  // Called at posedge+1 with the DUT idle; returns edges from accept to out_valid, -1 on timeout.
  task automatic send_pixel(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb, output int lat);
    r = rr; g = gg; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_pixel();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (hue !== 9'd0 || sat !== 8'd0 || val !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: hue=%0d sat=%0d val=%0d expected 0/0/0", hue, sat, val);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_conversion();
    int tv [7][6];
    int lat;
    tv = '{'{255, 0, 0, 0, 255, 255},
           '{0, 255, 0, 120, 255, 255},
           '{0, 0, 255, 240, 255, 255},
           '{255, 0, 128, 329, 255, 255},
           '{200, 100, 50, 20, 191, 200},
           '{100, 100, 100, 0, 0, 100},
           '{0, 0, 0, 0, 0, 0}};
    for (int k = 0; k < 7; k++) begin
      send_pixel(8'(tv[k][0]), 8'(tv[k][1]), 8'(tv[k][2]), lat);
      n_checks++;
      if (lat != LAT) begin
        n_fail++;
        $display("FAIL conv[%0d]_latency: got %0d expected %0d", k, lat, LAT);
      end
      n_checks++;
      if (hue !== 9'(tv[k][3])) begin
        n_fail++;
        $display("FAIL conv[%0d]_hue: got %0d expected %0d", k, hue, tv[k][3]);
      end
      n_checks++;
      if (sat !== 8'(exp_sat(tv[k][4]))) begin
        n_fail++;
        $display("FAIL conv[%0d]_sat: got %0d expected %0d", k, sat, exp_sat(tv[k][4]));
      end
      n_checks++;
      if (val !== 8'(tv[k][5])) begin
        n_fail++;
        $display("FAIL conv[%0d]_val: got %0d expected %0d", k, val, tv[k][5]);
      end
      release_pixel();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL conv[%0d]_release: in_ready=%b out_valid=%b expected 1/0", k, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send_pixel(8'd200, 8'd100, 8'd50, lat);
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d expected %0d", lat, LAT);
    end
    r = 8'd9; g = 8'd8; b = 8'd7; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || hue !== 9'd20 ||
          sat !== 8'(exp_sat(191)) || val !== 8'd200) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b hue=%0d sat=%0d val=%0d expected 1/0/20/%0d/200",
                 c, out_valid, in_ready, hue, sat, val, exp_sat(191));
      end
    end
    in_valid = 1'b0;
    release_pixel();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (hue !== 9'd20 || val !== 8'd200) begin
      n_fail++;
      $display("FAIL bp_keep_last: hue=%0d val=%0d expected 20/200", hue, val);
    end
    send_pixel(8'd0, 8'd0, 8'd255, lat);
    n_checks++;
    if (lat != LAT || hue !== 9'd240 || val !== 8'd255) begin
      n_fail++;
      $display("FAIL bp_next_pixel: lat=%0d hue=%0d val=%0d expected %0d/240/255", lat, hue, val, LAT);
    end
    release_pixel();
  endtask

  task automatic test_reset_midflight();
    int lat;
    r = 8'd255; g = 8'd0; b = 8'd128; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (hue !== 9'd0 || sat !== 8'd0 || val !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: hue=%0d sat=%0d val=%0d expected 0/0/0", hue, sat, val);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_pixel(8'd200, 8'd100, 8'd50, lat);
    n_checks++;
    if (lat != LAT || hue !== 9'd20 || sat !== 8'(exp_sat(191)) || val !== 8'd200) begin
      n_fail++;
      $display("FAIL midreset_recover: lat=%0d hue=%0d sat=%0d val=%0d expected %0d/20/%0d/200",
               lat, hue, sat, val, LAT, exp_sat(191));
    end
    release_pixel();
  endtask

  task automatic test_back_to_back();
    int first_acc, second_acc, ov_count;
    logic acc;
    first_acc = -1; second_acc = -1; ov_count = 0;
    out_ready = 1'b1;
    r = 8'd0; g = 8'd255; b = 8'd0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 3 * LAT + 10; cyc++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (out_valid === 1'b1) ov_count++;
      if (acc === 1'b1) begin
        if (first_acc < 0) first_acc = cyc;
        else begin
          second_acc = cyc;
          break;
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (second_acc < 0 || second_acc - first_acc != LAT + 2) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d expected %0d", second_acc - first_acc, LAT + 2);
    end
    n_checks++;
    if (ov_count != 1) begin
      n_fail++;
      $display("FAIL b2b_out_valid_cycles: got %0d expected 1", ov_count);
    end
    n_checks++;
    if (hue !== 9'd120 || val !== 8'd255) begin
      n_fail++;
      $display("FAIL b2b_result: hue=%0d val=%0d expected 120/255", hue, val);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_conversion();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
